// File: rtl/peri_bus_demux.sv
// ---------------------------------------------------------------------------
// peri_bus_demux
//
// Splits one peripheral-bus master across N_SLAVES address windows. Each
// request is decoded to a slave (lowest matching window wins) or to an
// internal error target when no window matches. A small FIFO remembers the
// target of every granted request so that responses are handed back to the
// master strictly in issue order.
//
// Optional watchdog: define PERI_BUS_TIMEOUT_EN to build a per-head counter
// that terminates a request with an error response when the slave at the
// FIFO head has not answered within TIMEOUT_CYCLES cycles. Without the macro
// no counter exists, timeout_o is tied low and a hung slave stalls forever.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_req/m_write/m_addr/
//   m_be/m_wdata             master request fields
//   m_gnt                    request accepted this cycle
//   m_rvalid/m_rdata/m_err   in-order response to the master
//   s_req                    per-slave request strobe
//   s_addr/s_write/s_be/
//   s_wdata                  request fields broadcast to all slaves
//   s_gnt/s_rvalid/s_err     per-slave grant / response / error
//   s_rdata                  per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   spurious_o               pulse: a response arrived from a slave not at the head
//   timeout_o                pulse: the watchdog terminated the head request
// ---------------------------------------------------------------------------
module peri_bus_demux #(
   parameter int unsigned                 N_SLAVES        = 4,
   parameter int unsigned                 ADDR_W          = 32,
   parameter int unsigned                 DATA_W          = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE        = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK        = '0,
   parameter int unsigned                 MAX_OUTSTANDING = 2,
   parameter int unsigned                 TIMEOUT_CYCLES  = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m_req,
   input  logic                         m_write,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic [DATA_W/8-1:0]          m_be,
   input  logic [DATA_W-1:0]            m_wdata,
   output logic                         m_gnt,
   output logic                         m_rvalid,
   output logic [DATA_W-1:0]            m_rdata,
   output logic                         m_err,
   output logic [N_SLAVES-1:0]          s_req,
   output logic [ADDR_W-1:0]            s_addr,
   output logic                         s_write,
   output logic [DATA_W/8-1:0]          s_be,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic [N_SLAVES-1:0]          s_gnt,
   input  logic [N_SLAVES-1:0]          s_rvalid,
   input  logic [N_SLAVES-1:0]          s_err,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
   output logic                         spurious_o,
   output logic                         timeout_o
);

   // Target ids 0..N_SLAVES-1 are slaves; N_SLAVES is the internal error target.
   localparam int unsigned TW = $clog2(N_SLAVES + 1);
   typedef logic [TW-1:0] tgt_t;
   localparam tgt_t ERR_ID = tgt_t'(N_SLAVES);

   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CW-1:0] FIFO_DEPTH = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);

   tgt_t            fifo_mem [MAX_OUTSTANDING];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   tgt_t            tail_id;

   tgt_t            dec_id;
   logic            dec_hit;
   tgt_t            head_id;
   logic            head_is_err;
   logic            fifo_empty;
   logic            fifo_full;
   logic [N_SLAVES-1:0] head_mask;
   logic            rsp_valid;
   logic            rsp_err;
   logic [DATA_W-1:0] rsp_data;
   logic            sel_gnt;
   logic            issue_ok;
   logic            push;
   logic            pop;
   logic            stray;
   logic            timeout_hit;
   logic            spurious_q;

   // Pointers wrap explicitly so any depth (including 1) behaves as a ring.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign s_addr  = m_addr;
   assign s_write = m_write;
   assign s_be    = m_be;
   assign s_wdata = m_wdata;

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == FIFO_DEPTH);
   assign head_id     = fifo_mem[rd_ptr];
   assign head_is_err = (head_id == ERR_ID);

   // Address decode: scan upwards and keep the first hit so the lowest
   // index wins when windows overlap; no hit leaves the error target.
   always_comb begin
      dec_id  = ERR_ID;
      dec_hit = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (!dec_hit &&
             ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
            dec_hit = 1'b1;
            dec_id  = tgt_t'(i);
         end
      end
   end

   // Response steering from the FIFO head. An error head (unmapped access
   // or watchdog expiry) answers on its own; a slave head forwards that
   // slave's response. Whatever is presented here is also the pop.
   always_comb begin
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      head_mask = '0;
      if (!fifo_empty) begin
         if (head_is_err || timeout_hit) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
         end else begin
            for (int i = 0; i < N_SLAVES; i++) begin
               if (head_id == tgt_t'(i)) begin
                  head_mask[i] = 1'b1;
                  rsp_valid    = s_rvalid[i];
                  rsp_err      = s_rvalid[i] & s_err[i];
                  rsp_data     = s_rdata[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign pop      = rsp_valid;
   assign m_rvalid = rsp_valid;
   assign m_err    = rsp_err;
   assign m_rdata  = rsp_valid ? rsp_data : '0;

   // Any slave response not consumed by the head is dropped and reported.
   assign stray = |(s_rvalid & ~head_mask);

   // Issue gating keeps all outstanding entries on one target, which is
   // what makes in-order return possible without reordering buffers. A
   // simultaneous pop frees the slot a full FIFO needs for the push.
   always_comb begin
      sel_gnt = 1'b0;
      s_req   = '0;
      issue_ok = !rst && (!fifo_full || pop) && (fifo_empty || (dec_id == tail_id));
      for (int i = 0; i < N_SLAVES; i++) begin
         if (dec_id == tgt_t'(i)) begin
            sel_gnt  = s_gnt[i];
            s_req[i] = issue_ok & m_req;
         end
      end
      m_gnt = issue_ok && m_req && ((dec_id == ERR_ID) || sel_gnt);
   end

   assign push = m_req & m_gnt;

   // Response-tracking FIFO: target ids in issue order, plus a copy of the
   // most recent push so the tail comparison needs no extra read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         tail_id  <= '0;
         fifo_mem <= '{default: '0};
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= dec_id;
            wr_ptr           <= ptr_next(wr_ptr);
            tail_id          <= dec_id;
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stray-response pulse, delayed one cycle so it is a clean register output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spurious_q <= 1'b0;
      end else begin
         spurious_q <= stray;
      end
   end

   assign spurious_o = spurious_q;

`ifdef PERI_BUS_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // wd_cnt holds the number of cycles the current slave head has already
   // waited, so the head expires in its TIMEOUT_CYCLES-th waiting cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (pop) begin
         wd_cnt <= '0;
      end else if (!fifo_empty && !head_is_err) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout_hit = !fifo_empty && !head_is_err && (wd_cnt == WD_LAST);

   // Expiry pulse, one cycle after the error response was presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_peri_bus_demux.sv
// ---------------------------------------------------------------------------
// tb_peri_bus_demux
//
// Self-checking bench for peri_bus_demux with four slaves at 256 MB windows
// (slave i owns addresses i<<28), two outstanding transactions and an
// eight-cycle watchdog limit (only active when PERI_BUS_TIMEOUT_EN is set).
// Directed scenarios cover the documented corner cases; a randomized phase
// compares every cycle against a transaction-level model that keeps the
// outstanding targets in a queue.
// ---------------------------------------------------------------------------
module tb_peri_bus_demux;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MO  = 2;
   localparam int TO  = 8;
   localparam int ERR_T = N;
   localparam logic [N*AW-1:0] BASES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [N*AW-1:0] MASKS = {N{32'hF000_0000}};

   logic              clk;
   logic              rst;
   logic              m_req;
   logic              m_write;
   logic [AW-1:0]     m_addr;
   logic [DW/8-1:0]   m_be;
   logic [DW-1:0]     m_wdata;
   logic              m_gnt;
   logic              m_rvalid;
   logic [DW-1:0]     m_rdata;
   logic              m_err;
   logic [N-1:0]      s_req;
   logic [AW-1:0]     s_addr;
   logic              s_write;
   logic [DW/8-1:0]   s_be;
   logic [DW-1:0]     s_wdata;
   logic [N-1:0]      s_gnt;
   logic [N-1:0]      s_rvalid;
   logic [N-1:0]      s_err;
   logic [N*DW-1:0]   s_rdata;
   logic              spurious_o;
   logic              timeout_o;

   int checks = 0;
   int errors = 0;

   // Reference-model state for the randomized phase.
   int exp_q[$];
   int wait_cnt;
   int pend[N];

   peri_bus_demux #(
      .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
      .SLV_BASE(BASES), .SLV_MASK(MASKS),
      .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
      .s_req(s_req), .s_addr(s_addr), .s_write(s_write), .s_be(s_be), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
      .spurious_o(spurious_o), .timeout_o(timeout_o)
   );

   // 10 ns clock; inputs change 1 ns after a rising edge, outputs are
   // sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every master and slave input to its idle value.
   task automatic clear_inputs();
      m_req    = 1'b0;
      m_write  = 1'b0;
      m_addr   = '0;
      m_be     = '0;
      m_wdata  = '0;
      s_gnt    = '0;
      s_rvalid = '0;
      s_err    = '0;
      s_rdata  = '0;
   endtask

   // Move to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Outputs must be quiet while reset is held and right after release.
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_err, spurious_o, timeout_o} !== 5'b0 || m_rdata !== '0 || s_req !== '0) begin
         errors++;
         $display("[TB] FAIL reset_hold got gnt=%0b rv=%0b err=%0b sp=%0b to=%0b rdata=%h sreq=%b want all 0",
                  m_gnt, m_rvalid, m_err, spurious_o, timeout_o, m_rdata, s_req);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_err, spurious_o, timeout_o} !== 5'b0 || m_rdata !== '0 || s_req !== '0) begin
         errors++;
         $display("[TB] FAIL reset_release got gnt=%0b rv=%0b sp=%0b to=%0b rdata=%h sreq=%b want all 0",
                  m_gnt, m_rvalid, spurious_o, timeout_o, m_rdata, s_req);
      end
      next_cycle();
   endtask

   // Read to slave 1: same-cycle grant, response two cycles later.
   task automatic test_read_slave1();
      m_req  = 1'b1;
      m_addr = 32'h1000_0004;
      s_gnt  = 4'b0010;
      @(negedge clk);
      checks++;
      if (s_req !== 4'b0010 || m_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rd1_issue got sreq=%b gnt=%0b want sreq=0010 gnt=1", s_req, m_gnt);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b0 || m_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL rd1_wait got rv=%0b rdata=%h want rv=0 rdata=0", m_rvalid, m_rdata);
      end
      next_cycle();
      s_rvalid = 4'b0010;
      s_rdata[1*DW +: DW] = 32'hCAFE_0001;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_0001 || m_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd1_resp got rv=%0b rdata=%h err=%0b want rv=1 rdata=cafe0001 err=0",
                  m_rvalid, m_rdata, m_err);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b0 || spurious_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd1_after got rv=%0b sp=%0b want 0 0", m_rvalid, spurious_o);
      end
      next_cycle();
   endtask

   // Unmapped address: internal grant, error response the next cycle.
   task automatic test_unmapped();
      m_req  = 1'b1;
      m_addr = 32'hF000_0000;
      @(negedge clk);
      checks++;
      if (m_gnt !== 1'b1 || s_req !== '0) begin
         errors++;
         $display("[TB] FAIL unmapped_issue got gnt=%0b sreq=%b want gnt=1 sreq=0000", m_gnt, s_req);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL unmapped_resp got rv=%0b err=%0b rdata=%h want 1 1 0", m_rvalid, m_err, m_rdata);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unmapped_once got rv=%0b want 0", m_rvalid);
      end
      next_cycle();
   endtask

   // Ordering and capacity stalls with two outstanding reads.
   task automatic test_back_to_back();
      m_req  = 1'b1;
      m_addr = 32'h0000_0010;
      s_gnt  = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (m_gnt !== 1'b1 || s_req !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL b2b_s0_%0d got gnt=%0b sreq=%b want gnt=1 sreq=0001", k, m_gnt, s_req);
         end
         next_cycle();
      end
      // Slave 2 request while two slave-0 reads are pending.
      m_addr = 32'h2000_0000;
      s_gnt  = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         s_rvalid = (k == 0) ? 4'b0000 : 4'b0001;
         s_rdata[0*DW +: DW] = 32'h5000_0000 + k;
         @(negedge clk);
         checks++;
         if (m_gnt !== 1'b0 || s_req !== 4'b0000 || m_rvalid !== (k != 0)) begin
            errors++;
            $display("[TB] FAIL b2b_stall_%0d got gnt=%0b sreq=%b rv=%0b want gnt=0 sreq=0000 rv=%0b",
                     k, m_gnt, s_req, m_rvalid, (k != 0));
         end
         if (k != 0) begin
            checks++;
            if (m_rdata !== 32'h5000_0000 + k) begin
               errors++;
               $display("[TB] FAIL b2b_rdata_%0d got %h want %h", k, m_rdata, 32'h5000_0000 + k);
            end
         end
         next_cycle();
      end
      s_rvalid = '0;
      // FIFO now empty: slave 2 goes out, then a second slave 2 fills it.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (m_gnt !== 1'b1 || s_req !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL b2b_s2_%0d got gnt=%0b sreq=%b want gnt=1 sreq=0100", k, m_gnt, s_req);
         end
         next_cycle();
      end
      // Slave 0 request while full: stalls through both slave-2 pops.
      m_addr = 32'h0000_0020;
      s_gnt  = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         s_rvalid = (k == 0) ? 4'b0000 : 4'b0100;
         @(negedge clk);
         checks++;
         if (m_gnt !== 1'b0 || s_req !== 4'b0000 || m_rvalid !== (k != 0)) begin
            errors++;
            $display("[TB] FAIL b2b_full_%0d got gnt=%0b sreq=%b rv=%0b want gnt=0 sreq=0000 rv=%0b",
                     k, m_gnt, s_req, m_rvalid, (k != 0));
         end
         next_cycle();
      end
      s_rvalid = '0;
      @(negedge clk);
      checks++;
      if (m_gnt !== 1'b1 || s_req !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL b2b_s0_late got gnt=%0b sreq=%b want gnt=1 sreq=0001", m_gnt, s_req);
      end
      next_cycle();
      clear_inputs();
      s_rvalid = 4'b0001;
      s_rdata[0*DW +: DW] = 32'h0BAD_F00D;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("[TB] FAIL b2b_drain got rv=%0b rdata=%h want 1 0badf00d", m_rvalid, m_rdata);
      end
      next_cycle();
      clear_inputs();
   endtask

   // Response from slave 3 with nothing outstanding.
   task automatic test_stray();
      s_rvalid = 4'b1000;
      s_rdata[3*DW +: DW] = 32'h1111_2222;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b0 || m_rdata !== '0 || spurious_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stray_now got rv=%0b rdata=%h sp=%0b want 0 0 0", m_rvalid, m_rdata, spurious_o);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (spurious_o !== 1'b1 || m_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stray_pulse got sp=%0b rv=%0b want sp=1 rv=0", spurious_o, m_rvalid);
      end
      next_cycle();
      // An unmapped access must answer next cycle, proving nothing was queued.
      m_req  = 1'b1;
      m_addr = 32'hA000_0000;
      @(negedge clk);
      checks++;
      if (spurious_o !== 1'b0 || m_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stray_end got sp=%0b gnt=%0b want sp=0 gnt=1", spurious_o, m_gnt);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stray_count got rv=%0b err=%0b want 1 1", m_rvalid, m_err);
      end
      next_cycle();
   endtask

   // Slave 1 grants and never answers.
   task automatic test_timeout();
      int seen;
      m_req  = 1'b1;
      m_addr = 32'h1000_0040;
      s_gnt  = 4'b0010;
      @(negedge clk);
      checks++;
      if (m_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL to_issue got gnt=%0b want 1", m_gnt);
      end
      next_cycle();
      clear_inputs();
`ifdef PERI_BUS_TIMEOUT_EN
      seen = 0;
      for (int k = 1; k < TO; k++) begin
         @(negedge clk);
         if (m_rvalid !== 1'b0 || timeout_o !== 1'b0) seen++;
         next_cycle();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL to_early got %0d early responses want 0", seen);
      end
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== '0 || timeout_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL to_expire got rv=%0b err=%0b rdata=%h to=%0b want 1 1 0 0",
                  m_rvalid, m_err, m_rdata, timeout_o);
      end
      next_cycle();
      s_rvalid = 4'b0010;
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b1 || m_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL to_pulse got to=%0b rv=%0b want to=1 rv=0", timeout_o, m_rvalid);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b0 || spurious_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL to_late got to=%0b sp=%0b want to=0 sp=1", timeout_o, spurious_o);
      end
      next_cycle();
`else
      seen = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (m_rvalid !== 1'b0 || timeout_o !== 1'b0) seen++;
         next_cycle();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL to_none got %0b responses in 1000 cycles want 0", seen);
      end
      s_rvalid = 4'b0010;
      s_rdata[1*DW +: DW] = 32'h7777_0001;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h7777_0001) begin
         errors++;
         $display("[TB] FAIL to_drain got rv=%0b err=%0b rdata=%h want 1 0 77770001", m_rvalid, m_err, m_rdata);
      end
      next_cycle();
      clear_inputs();
`endif
   endtask

   // Reset arrives with two reads outstanding.
   task automatic test_reset_mid();
      m_req  = 1'b1;
      m_addr = 32'h0000_0100;
      s_gnt  = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (m_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_issue_%0d got gnt=%0b want 1", k, m_gnt);
         end
         next_cycle();
      end
      clear_inputs();
      s_rvalid = 4'b0001;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_err, spurious_o, timeout_o} !== 5'b0 || m_rdata !== '0 || s_req !== '0) begin
         errors++;
         $display("[TB] FAIL rstmid_hold got gnt=%0b rv=%0b err=%0b sp=%0b to=%0b rdata=%h want all 0",
                  m_gnt, m_rvalid, m_err, spurious_o, timeout_o, m_rdata);
      end
      next_cycle();
      rst = 1'b0;
      s_rvalid = '0;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, spurious_o, timeout_o} !== 4'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_release got gnt=%0b rv=%0b sp=%0b to=%0b want all 0",
                  m_gnt, m_rvalid, spurious_o, timeout_o);
      end
      next_cycle();
      // A slave-0 response now has nobody waiting for it.
      s_rvalid = 4'b0001;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_empty got rv=%0b want 0", m_rvalid);
      end
      next_cycle();
      clear_inputs();
      m_req  = 1'b1;
      m_addr = 32'h0000_0200;
      s_gnt  = 4'b0001;
      @(negedge clk);
      checks++;
      if (spurious_o !== 1'b1 || m_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rstmid_read_issue got sp=%0b gnt=%0b want 1 1", spurious_o, m_gnt);
      end
      next_cycle();
      clear_inputs();
      s_rvalid = 4'b0001;
      s_rdata[0*DW +: DW] = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_read_resp got rv=%0b rdata=%h err=%0b want 1 12345678 0",
                  m_rvalid, m_rdata, m_err);
      end
      next_cycle();
      clear_inputs();
   endtask

   // Randomized traffic against a queue-based model of the outstanding
   // targets; bench slaves answer only what they granted, plus occasional
   // unsolicited responses from idle slaves.
   task automatic test_random(input int cycles);
      int sel, tgt, head, tail;
      bit empty, full, to_now, pop, can, gnt_e, stray_e, rv_e, err_e;
      bit prev_stray, prev_to;
      logic [DW-1:0] rd_e;
      logic [N-1:0]  sreq_e;
      exp_q.delete();
      wait_cnt   = 0;
      prev_stray = 1'b0;
      prev_to    = 1'b0;
      foreach (pend[j]) pend[j] = 0;
      for (int c = 0; c < cycles; c++) begin
         m_req   = ($urandom_range(0, 3) != 0);
         sel     = $urandom_range(0, 5);
         m_addr  = $urandom;
         m_addr[31:28] = (sel < N) ? 4'(sel) : 4'($urandom_range(4, 15));
         m_write = 1'($urandom);
         m_be    = 4'($urandom);
         m_wdata = $urandom;
         for (int j = 0; j < N; j++) begin
            s_gnt[j]    = ($urandom_range(0, 3) != 0);
            s_rvalid[j] = (pend[j] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            s_err[j]    = ($urandom_range(0, 3) == 0);
            s_rdata[j*DW +: DW] = $urandom;
         end

         tgt   = (int'(m_addr[31:28]) < N) ? int'(m_addr[31:28]) : ERR_T;
         empty = (exp_q.size() == 0);
         full  = (exp_q.size() == MO);
         head  = empty ? -1 : exp_q[0];
         tail  = empty ? -1 : exp_q[$];
         to_now = 1'b0;
`ifdef PERI_BUS_TIMEOUT_EN
         to_now = !empty && head != ERR_T && (wait_cnt + 1 == TO);
`endif
         rv_e = 1'b0;
         err_e = 1'b0;
         rd_e = '0;
         if (!empty) begin
            if (head == ERR_T || to_now) begin
               rv_e  = 1'b1;
               err_e = 1'b1;
            end else if (s_rvalid[head]) begin
               rv_e  = 1'b1;
               err_e = s_err[head];
               rd_e  = s_rdata[head*DW +: DW];
            end
         end
         pop = rv_e;
         stray_e = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (s_rvalid[j] && !(!empty && j == head && !to_now)) stray_e = 1'b1;
         end
         can    = m_req && (!full || pop) && (empty || tgt == tail);
         gnt_e  = can && (tgt == ERR_T || s_gnt[tgt]);
         sreq_e = '0;
         if (can && tgt != ERR_T) sreq_e[tgt] = 1'b1;

         @(negedge clk);
         checks++;
         if (m_gnt !== gnt_e || s_req !== sreq_e) begin
            errors++;
            $display("[TB] FAIL rnd_issue c=%0d got gnt=%0b sreq=%b want gnt=%0b sreq=%b",
                     c, m_gnt, s_req, gnt_e, sreq_e);
         end
         checks++;
         if (m_rvalid !== rv_e || m_rdata !== rd_e || (rv_e && m_err !== err_e)) begin
            errors++;
            $display("[TB] FAIL rnd_resp c=%0d got rv=%0b rdata=%h err=%0b want rv=%0b rdata=%h err=%0b",
                     c, m_rvalid, m_rdata, m_err, rv_e, rd_e, err_e);
         end
         checks++;
         if (spurious_o !== prev_stray || timeout_o !== prev_to) begin
            errors++;
            $display("[TB] FAIL rnd_pulse c=%0d got sp=%0b to=%0b want sp=%0b to=%0b",
                     c, spurious_o, timeout_o, prev_stray, prev_to);
         end

         @(posedge clk);
         if (pop) begin
            void'(exp_q.pop_front());
            wait_cnt = 0;
         end else if (!empty && head != ERR_T) begin
            wait_cnt++;
         end
         for (int j = 0; j < N; j++) begin
            if (s_rvalid[j] && pend[j] > 0) pend[j]--;
         end
         if (gnt_e) begin
            exp_q.push_back(tgt);
            if (tgt != ERR_T) pend[tgt]++;
         end
         prev_stray = stray_e;
         prev_to    = to_now;
         #1;
      end
      clear_inputs();
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_read_slave1();
      test_unmapped();
      test_back_to_back();
      test_stray();
      test_timeout();
      test_reset_mid();
      test_random(400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
